// File: rtl/paddle_pkg.sv
// Shared definitions for the paddle controller: state/direction encodings,
// default geometry and timing constants, and the speed-to-step table.
package paddle_pkg;

  localparam int SCREEN_W_DEF = 640;
  localparam int PAD_W_DEF    = 64;
  localparam int X_INIT_DEF   = 288;
  localparam int TICK_DIV_DEF = 250000;
  localparam int REP_DLY_DEF  = 20;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_DELAY  = 2'd2,
    ST_REPEAT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_L    = 2'd1,
    DIR_R    = 2'd2
  } dir_t;

  // Speed 0 never reaches the latch, so it shares the slowest step.
  function automatic logic [10:0] step_px(input logic [1:0] spd);
    logic [10:0] px;
    case (spd)
      2'd2:    px = 11'd4;
      2'd3:    px = 11'd8;
      default: px = 11'd2;
    endcase
    return px;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle registered tick every DIV clocks,
// first tick DIV cycles after reset release; no backpressure.
module tick_gen
  import paddle_pkg::*;
#(
  parameter int DIV = TICK_DIV_DEF
) (
  input  logic clk25,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;
  logic          w_wrap;

  assign w_wrap = (r_cnt == LAST);

  always_ff @(posedge clk25 or negedge clr) begin
    if (!clr) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_wrap;
      r_cnt  <= w_wrap ? '0 : r_cnt + CW'(1);
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/paddle_ctrl.sv
// Keyboard paddle mover: immediate first step, hold-off delay, then tick-paced
// auto-repeat with clamped position; all outputs registered, one cycle after the step decision.
module paddle_ctrl
  import paddle_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int PAD_W    = PAD_W_DEF,
  parameter int X_INIT   = X_INIT_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int REP_DLY  = REP_DLY_DEF
) (
  input  logic       clk25,
  input  logic       clr,
  input  logic       left,
  input  logic       right,
  input  logic [1:0] mode,
  output logic [9:0] paddle_x,
  output logic [1:0] speed,
  output logic       moving,
  output logic       edge_l,
  output logic       edge_r
);

  localparam logic [10:0] X_MAX   = 11'(SCREEN_W - PAD_W);
  localparam int          DW      = (REP_DLY > 0) ? $clog2(REP_DLY + 1) : 1;
  localparam logic [DW-1:0] DLY_END = DW'(REP_DLY);

  logic          w_tick;
  dir_t          w_dir;
  dir_t          r_dir;
  dir_t          w_dir_nxt;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [DW-1:0] r_dly;
  logic [DW-1:0] w_dly_nxt;
  logic [DW-1:0] w_dly_inc;
  logic          w_step;

  logic [9:0]    r_x;
  logic [1:0]    r_speed;
  logic          r_moving;
  logic          r_edge_l;
  logic          r_edge_r;
  logic [10:0]   w_x11;
  logic [10:0]   w_step_px;
  logic [10:0]   w_x_step;
  logic [10:0]   w_x_nxt;

  tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick_gen (
    .clk25 (clk25),
    .clr   (clr),
    .tick  (w_tick)
  );

  // Both keys held cancel each other out.
  always_comb begin
    w_dir = DIR_NONE;
    if (left && !right) begin
      w_dir = DIR_L;
    end else if (right && !left) begin
      w_dir = DIR_R;
    end
  end

  assign w_dly_inc = r_dly + DW'(1);

  // r_dir is latched on entry to FIRST so a one-cycle key tap still steps.
  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_dly_nxt   = r_dly;
    w_step      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_dir != DIR_NONE) begin
          w_state_nxt = ST_FIRST;
          w_dir_nxt   = w_dir;
        end
      end
      ST_FIRST: begin
        w_step      = 1'b1;
        w_state_nxt = ST_DELAY;
        w_dly_nxt   = '0;
      end
      ST_DELAY, ST_REPEAT: begin
        if (w_dir == DIR_NONE) begin
          w_state_nxt = ST_IDLE;
        end else if (w_dir != r_dir) begin
          w_state_nxt = ST_FIRST;
          w_dir_nxt   = w_dir;
        end else if (w_tick) begin
          if (r_state == ST_DELAY) begin
            w_dly_nxt = w_dly_inc;
            if (w_dly_inc == DLY_END) begin
              w_state_nxt = ST_REPEAT;
            end
          end else begin
            w_step = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_dir_nxt   = DIR_NONE;
      end
    endcase
  end

  always_ff @(posedge clk25 or negedge clr) begin
    if (!clr) begin
      r_state <= ST_IDLE;
      r_dir   <= DIR_NONE;
      r_dly   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
      r_dly   <= w_dly_nxt;
    end
  end

  // 11-bit arithmetic so the right-hand clamp sees the true sum.
  assign w_x11     = {1'b0, r_x};
  assign w_step_px = step_px(r_speed);

  always_comb begin
    w_x_step = w_x11;
    if (r_dir == DIR_L) begin
      w_x_step = (w_x11 < w_step_px) ? 11'd0 : (w_x11 - w_step_px);
    end else if (r_dir == DIR_R) begin
      w_x_step = ((w_x11 + w_step_px) > X_MAX) ? X_MAX : (w_x11 + w_step_px);
    end
  end

  assign w_x_nxt = w_step ? w_x_step : w_x11;

  always_ff @(posedge clk25 or negedge clr) begin
    if (!clr) begin
      r_x      <= 10'(X_INIT);
      r_speed  <= 2'd1;
      r_moving <= 1'b0;
      r_edge_l <= 1'b0;
      r_edge_r <= 1'b0;
    end else begin
      r_x      <= w_x_nxt[9:0];
      r_moving <= (w_state_nxt != ST_IDLE);
      r_edge_l <= (w_x_nxt == 11'd0);
      r_edge_r <= (w_x_nxt == X_MAX);
      if (mode != 2'd0) begin
        r_speed <= mode;
      end
    end
  end

  assign paddle_x = r_x;
  assign speed    = r_speed;
  assign moving   = r_moving;
  assign edge_l   = r_edge_l;
  assign edge_r   = r_edge_r;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl with TICK_DIV=4, REP_DLY=3; a second instance
// starts at x=3 to reach the left clamp from an odd position.
module tb_paddle_ctrl;

  logic       clk25 = 1'b0;
  logic       clr   = 1'b0;
  logic       left  = 1'b0;
  logic       right = 1'b0;
  logic [1:0] mode  = 2'd0;

  logic [9:0] paddle_x, paddle_x2;
  logic [1:0] speed, speed2;
  logic       moving, moving2;
  logic       edge_l, edge_l2;
  logic       edge_r, edge_r2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk25 = ~clk25;

  paddle_ctrl #(
    .SCREEN_W (640), .PAD_W (64), .X_INIT (288), .TICK_DIV (4), .REP_DLY (3)
  ) u_dut (
    .clk25 (clk25), .clr (clr), .left (left), .right (right), .mode (mode),
    .paddle_x (paddle_x), .speed (speed), .moving (moving),
    .edge_l (edge_l), .edge_r (edge_r)
  );

  paddle_ctrl #(
    .SCREEN_W (640), .PAD_W (64), .X_INIT (3), .TICK_DIV (4), .REP_DLY (3)
  ) u_dut2 (
    .clk25 (clk25), .clr (clr), .left (left), .right (right), .mode (mode),
    .paddle_x (paddle_x2), .speed (speed2), .moving (moving2),
    .edge_l (edge_l2), .edge_r (edge_r2)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk25);
  endtask

  // Leaves the bench on the negedge at which clr is released (cycle N0).
  task automatic do_reset();
    clr   = 1'b0;
    left  = 1'b0;
    right = 1'b0;
    mode  = 2'd0;
    cyc(3);
    clr = 1'b1;
  endtask

  task automatic test_reset();
    clr = 1'b0; left = 1'b0; right = 1'b0; mode = 2'd0;
    cyc(2);
    n_chk++; if (paddle_x !== 10'd288) begin n_fail++; $display("FAIL rst_x: got %0d want 288", paddle_x); end
    n_chk++; if (speed !== 2'd1) begin n_fail++; $display("FAIL rst_speed: got %0d want 1", speed); end
    n_chk++; if (moving !== 1'b0) begin n_fail++; $display("FAIL rst_moving: got %b want 0", moving); end
    n_chk++; if (edge_l !== 1'b0 || edge_r !== 1'b0) begin n_fail++; $display("FAIL rst_edges: got l=%b r=%b want 0/0", edge_l, edge_r); end
    n_chk++; if (paddle_x2 !== 10'd3) begin n_fail++; $display("FAIL rst_x2: got %0d want 3", paddle_x2); end
    mode = 2'd3;
    cyc(2);
    n_chk++; if (speed !== 2'd1) begin n_fail++; $display("FAIL rst_speed_hold: got %0d want 1", speed); end
    mode = 2'd0;
  endtask

  task automatic test_tap_left();
    do_reset();
    cyc(1);
    left = 1'b1;
    cyc(1);
    left = 1'b0;
    n_chk++; if (paddle_x !== 10'd288 || moving !== 1'b1) begin n_fail++; $display("FAIL tap_enter: got x=%0d mv=%b want 288/1", paddle_x, moving); end
    cyc(1);
    n_chk++; if (paddle_x !== 10'd286 || moving !== 1'b1) begin n_fail++; $display("FAIL tap_step: got x=%0d mv=%b want 286/1", paddle_x, moving); end
    cyc(1);
    n_chk++; if (moving !== 1'b0) begin n_fail++; $display("FAIL tap_idle: got mv=%b want 0", moving); end
    cyc(12);
    n_chk++; if (paddle_x !== 10'd286 || moving !== 1'b0) begin n_fail++; $display("FAIL tap_no_more: got x=%0d mv=%b want 286/0", paddle_x, moving); end
  endtask

  task automatic test_right_saturate();
    do_reset();
    mode  = 2'd3;
    right = 1'b1;
    cyc(1);
    mode = 2'd0;
    n_chk++; if (speed !== 2'd3 || moving !== 1'b1 || paddle_x !== 10'd288) begin n_fail++; $display("FAIL r_enter: got sp=%0d mv=%b x=%0d want 3/1/288", speed, moving, paddle_x); end
    cyc(1);
    n_chk++; if (paddle_x !== 10'd296) begin n_fail++; $display("FAIL r_first: got %0d want 296", paddle_x); end
    cyc(14);
    n_chk++; if (paddle_x !== 10'd296) begin n_fail++; $display("FAIL r_delay_hold: got %0d want 296", paddle_x); end
    cyc(1);
    n_chk++; if (paddle_x !== 10'd304) begin n_fail++; $display("FAIL r_rep1: got %0d want 304", paddle_x); end
    cyc(3);
    n_chk++; if (paddle_x !== 10'd304) begin n_fail++; $display("FAIL r_rep_gap: got %0d want 304", paddle_x); end
    cyc(1);
    n_chk++; if (paddle_x !== 10'd312) begin n_fail++; $display("FAIL r_rep2: got %0d want 312", paddle_x); end
    cyc(131);
    n_chk++; if (paddle_x !== 10'd568 || edge_r !== 1'b0) begin n_fail++; $display("FAIL r_near_edge: got x=%0d er=%b want 568/0", paddle_x, edge_r); end
    cyc(1);
    n_chk++; if (paddle_x !== 10'd576 || edge_r !== 1'b1) begin n_fail++; $display("FAIL r_at_edge: got x=%0d er=%b want 576/1", paddle_x, edge_r); end
    cyc(17);
    n_chk++; if (paddle_x !== 10'd576 || edge_r !== 1'b1 || moving !== 1'b1) begin n_fail++; $display("FAIL r_sat: got x=%0d er=%b mv=%b want 576/1/1", paddle_x, edge_r, moving); end
    clr = 1'b0;
    #1;
    n_chk++; if (paddle_x !== 10'd288 || moving !== 1'b0 || speed !== 2'd1 || edge_r !== 1'b0) begin n_fail++; $display("FAIL r_abort: got x=%0d mv=%b sp=%0d er=%b want 288/0/1/0", paddle_x, moving, speed, edge_r); end
    @(negedge clk25);
    clr = 1'b1;
    cyc(1);
    n_chk++; if (paddle_x !== 10'd288 || moving !== 1'b1) begin n_fail++; $display("FAIL r_fresh_first: got x=%0d mv=%b want 288/1", paddle_x, moving); end
    cyc(1);
    n_chk++; if (paddle_x !== 10'd290) begin n_fail++; $display("FAIL r_fresh_step: got %0d want 290", paddle_x); end
    right = 1'b0;
  endtask

  task automatic test_left_clamp();
    do_reset();
    mode = 2'd2;
    left = 1'b1;
    cyc(1);
    mode = 2'd0;
    n_chk++; if (paddle_x2 !== 10'd3 || speed2 !== 2'd2 || edge_l2 !== 1'b0) begin n_fail++; $display("FAIL l_enter: got x=%0d sp=%0d el=%b want 3/2/0", paddle_x2, speed2, edge_l2); end
    cyc(1);
    n_chk++; if (paddle_x2 !== 10'd0 || edge_l2 !== 1'b1) begin n_fail++; $display("FAIL l_clamp: got x=%0d el=%b want 0/1", paddle_x2, edge_l2); end
    n_chk++; if (paddle_x !== 10'd284) begin n_fail++; $display("FAIL l_main_step: got %0d want 284", paddle_x); end
    cyc(20);
    n_chk++; if (paddle_x2 !== 10'd0 || edge_l2 !== 1'b1 || moving2 !== 1'b1) begin n_fail++; $display("FAIL l_hold: got x=%0d el=%b mv=%b want 0/1/1", paddle_x2, edge_l2, moving2); end
    n_chk++; if (paddle_x !== 10'd276) begin n_fail++; $display("FAIL l_main_rep: got %0d want 276", paddle_x); end
    left = 1'b0;
  endtask

  task automatic test_both_keys();
    do_reset();
    left  = 1'b1;
    right = 1'b1;
    cyc(2);
    n_chk++; if (moving !== 1'b0 || paddle_x !== 10'd288) begin n_fail++; $display("FAIL both_early: got mv=%b x=%0d want 0/288", moving, paddle_x); end
    cyc(18);
    n_chk++; if (moving !== 1'b0 || paddle_x !== 10'd288) begin n_fail++; $display("FAIL both_late: got mv=%b x=%0d want 0/288", moving, paddle_x); end
    left  = 1'b0;
    right = 1'b0;
  endtask

  task automatic test_reverse();
    do_reset();
    left = 1'b1;
    cyc(17);
    n_chk++; if (paddle_x !== 10'd284) begin n_fail++; $display("FAIL rev_left_rep: got %0d want 284", paddle_x); end
    cyc(1);
    left  = 1'b0;
    right = 1'b1;
    cyc(1);
    n_chk++; if (paddle_x !== 10'd284 || moving !== 1'b1) begin n_fail++; $display("FAIL rev_first_entry: got x=%0d mv=%b want 284/1", paddle_x, moving); end
    cyc(1);
    n_chk++; if (paddle_x !== 10'd286) begin n_fail++; $display("FAIL rev_first_step: got %0d want 286", paddle_x); end
    cyc(12);
    n_chk++; if (paddle_x !== 10'd286) begin n_fail++; $display("FAIL rev_delay: got %0d want 286", paddle_x); end
    cyc(1);
    n_chk++; if (paddle_x !== 10'd288) begin n_fail++; $display("FAIL rev_repeat: got %0d want 288", paddle_x); end
    right = 1'b0;
  endtask

  task automatic test_speed_change();
    do_reset();
    right = 1'b1;
    cyc(17);
    n_chk++; if (paddle_x !== 10'd292) begin n_fail++; $display("FAIL spd_pre: got %0d want 292", paddle_x); end
    cyc(1);
    mode = 2'd2;
    cyc(1);
    mode = 2'd0;
    n_chk++; if (speed !== 2'd2 || moving !== 1'b1) begin n_fail++; $display("FAIL spd_latch: got sp=%0d mv=%b want 2/1", speed, moving); end
    cyc(2);
    n_chk++; if (paddle_x !== 10'd296) begin n_fail++; $display("FAIL spd_step4: got %0d want 296", paddle_x); end
    cyc(4);
    n_chk++; if (paddle_x !== 10'd300 || speed !== 2'd2) begin n_fail++; $display("FAIL spd_persist: got x=%0d sp=%0d want 300/2", paddle_x, speed); end
    cyc(1);
    right = 1'b0;
    cyc(1);
    n_chk++; if (moving !== 1'b0 || paddle_x !== 10'd300) begin n_fail++; $display("FAIL spd_release: got mv=%b x=%0d want 0/300", moving, paddle_x); end
  endtask

  initial begin
    test_reset();
    test_tap_left();
    test_right_saturate();
    test_left_clamp();
    test_both_keys();
    test_reverse();
    test_speed_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
